// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: mux selector codes,
// shadow-stage entry layout and the selector priority function.
package fwd_pkg;

  localparam int RA_W_DEF = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_MEMWB   = 2'd1;
  localparam logic [1:0] FWD_EXMEM   = 2'd2;

  localparam int NSTAGE = 3;
  localparam int IDEX   = 0;
  localparam int EXMEM  = 1;
  localparam int MEMWB  = 2;

  typedef struct packed {
    logic                valid;
    logic [RA_W_DEF-1:0] dest;
    logic                regwrite;
    logic                memread;
  } stage_t;

  // Register 0 is hard-wired, so a write to it is never a forwarding source.
  function automatic logic is_live(input stage_t s);
    return s.valid & s.regwrite & (s.dest != '0);
  endfunction

  // The newer producer wins. IDEX moves to EX/MEM while the consumer is in EX,
  // and EXMEM moves to MEM/WB.
  function automatic logic [1:0] fwd_select(input stage_t idex, input stage_t exmem,
                                            input logic used, input logic [RA_W_DEF-1:0] src);
    if (!used)                                return FWD_REGFILE;
    if (is_live(idex)  && idex.dest  == src)  return FWD_EXMEM;
    if (is_live(exmem) && exmem.dest == src)  return FWD_MEMWB;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One shadow pipeline entry: synchronous active-low clear, bubble load.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk) begin
    if (!reset)      q <= '0;
    else if (bubble) q <= '0;
    else             q <= d;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding selectors and load-use stall generation.
// Optional HAZARD_STATS_EN adds saturating stall/forward counters.
// The RA_W parameter must match fwd_pkg::RA_W_DEF, which sizes the shadow entries.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] fwd_count
);

  stage_t     stg [NSTAGE];
  stage_t     entry;
  logic       accept;
  logic [1:0] sel_a, sel_b;

  always_comb begin
    stall = id_valid & ~flush & is_live(stg[IDEX]) & stg[IDEX].memread &
            ((id_uses_rs & (id_rs == stg[IDEX].dest)) |
             (id_uses_rt & (id_rt == stg[IDEX].dest)));
  end

  assign accept = id_valid & ~stall & ~flush;
  assign entry  = '{valid: 1'b1, dest: id_dest, regwrite: id_regwrite, memread: id_memread};
  assign sel_a  = fwd_select(stg[IDEX], stg[EXMEM], id_uses_rs, id_rs);
  assign sel_b  = fwd_select(stg[IDEX], stg[EXMEM], id_uses_rt, id_rt);

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stg
    stage_t d;
    logic   bub;
    if (i == 0) begin : g_head
      assign d   = entry;
      assign bub = ~accept;
    end else begin : g_tail
      assign d   = stg[i-1];
      assign bub = 1'b0;
    end
    fwd_stage_reg u_stg (.clk(clk), .reset(reset), .bubble(bub), .d(d), .q(stg[i]));
  end

  // Selectors line up with the instruction entering EX; bubbles read the regfile.
  always_ff @(posedge clk) begin
    if (!reset) begin
      forward_a <= FWD_REGFILE;
      forward_b <= FWD_REGFILE;
    end else if (accept) begin
      forward_a <= sel_a;
      forward_b <= sel_b;
    end else begin
      forward_a <= FWD_REGFILE;
      forward_b <= FWD_REGFILE;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (accept && (sel_a != FWD_REGFILE || sel_b != FWD_REGFILE) && fwd_count != '1)
        fwd_count <= fwd_count + CNT_W'(1);
    end
  end
`else
  assign stall_count = '0;
  assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed checks of forwarding selectors, load-use stall, flush and reset.
module tb_fwd_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 32;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
  logic [RA_W-1:0]  id_rs, id_rt, id_dest;
  logic             stall;
  logic [1:0]       forward_a, forward_b;
  logic [CNT_W-1:0] stall_count, fwd_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall), .forward_a(forward_a), .forward_b(forward_b),
    .stall_count(stall_count), .fwd_count(fwd_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                    input int dest, input logic rw, input logic mr);
    id_valid = v; id_rs = RA_W'(rs); id_rt = RA_W'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = RA_W'(dest); id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic drain();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b1; #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fa", 32'(forward_a), 0);
    chk("rst_fb", 32'(forward_b), 0);
    chk("rst_scnt", stall_count, 0);
    chk("rst_fcnt", fwd_count, 0);

    // add $3,$1,$2 ; add $4,$3,$3
    id(1, 1, 2, 1, 1, 3, 1, 0);
    chk("t1_nostall", 32'(stall), 0);
    tick();
    chk("t1_prod_fa", 32'(forward_a), 0);
    id(1, 3, 3, 1, 1, 4, 1, 0);
    chk("t1_cons_stall", 32'(stall), 0);
    tick();
    chk("t1_fa", 32'(forward_a), 2);
    chk("t1_fb", 32'(forward_b), 2);
    drain();

    // add $3 ; nop ; sub $5,$3,$1
    id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    id(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("t2_nop_fa", 32'(forward_a), 0);
    id(1, 3, 1, 1, 1, 5, 1, 0); tick();
    chk("t2_fa", 32'(forward_a), 1);
    chk("t2_fb", 32'(forward_b), 0);
    drain();

    // lw $2 ; add $6,$2,$7
    id(1, 1, 0, 1, 0, 2, 1, 1); tick();
    id(1, 2, 7, 1, 1, 6, 1, 0);
    chk("t3_stall", 32'(stall), 1);
    tick();
    chk("t3_bub_fa", 32'(forward_a), 0);
    chk("t3_bub_fb", 32'(forward_b), 0);
    chk("t3_retry_stall", 32'(stall), 0);
    tick();
    chk("t3_fa", 32'(forward_a), 1);
    chk("t3_fb", 32'(forward_b), 0);
    chk("t3_scnt", stall_count, STATS ? 1 : 0);
    chk("t3_fcnt", fwd_count, STATS ? 3 : 0);
    drain();

    // add $0 ; use $0
    id(1, 1, 1, 1, 1, 0, 1, 0); tick();
    id(1, 0, 0, 1, 1, 9, 1, 0);
    chk("t4_r0_stall", 32'(stall), 0);
    tick();
    chk("t4_r0_fa", 32'(forward_a), 0);
    chk("t4_r0_fb", 32'(forward_b), 0);
    // lw $0 ; use $0 must not stall
    id(1, 1, 0, 1, 0, 0, 1, 1); tick();
    id(1, 0, 0, 1, 1, 9, 1, 0);
    chk("t4_lw0_stall", 32'(stall), 0);
    drain();
    // add $8 ; add $8 ; use $8 -> newer (EX/MEM) wins
    id(1, 1, 1, 1, 1, 8, 1, 0); tick();
    id(1, 1, 1, 1, 1, 8, 1, 0); tick();
    id(1, 8, 8, 1, 1, 10, 1, 0); tick();
    chk("t4_new_fa", 32'(forward_a), 2);
    chk("t4_new_fb", 32'(forward_b), 2);
    chk("t4_fcnt", fwd_count, STATS ? 4 : 0);
    drain();

    // lw $2 ; dependent add with flush in the same cycle
    id(1, 1, 0, 1, 0, 2, 1, 1); tick();
    flush = 1'b1;
    id(1, 3, 2, 1, 1, 6, 1, 0);
    chk("t5_flush_stall", 32'(stall), 0);
    tick();
    flush = 1'b0;
    chk("t5_fa", 32'(forward_a), 0);
    chk("t5_fb", 32'(forward_b), 0);
    chk("t5_scnt", stall_count, STATS ? 1 : 0);
    drain();

    // reset asserted during a stall cycle (rt-only dependency)
    id(1, 1, 0, 1, 0, 2, 1, 1); tick();
    id(1, 3, 2, 1, 1, 6, 1, 0);
    chk("t6_stall", 32'(stall), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1; #1;
    chk("t6_stall_after", 32'(stall), 0);
    chk("t6_fa", 32'(forward_a), 0);
    chk("t6_fb", 32'(forward_b), 0);
    chk("t6_scnt", stall_count, 0);
    chk("t6_fcnt", fwd_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
